d_ctrl_hazard: RTL and testbench

Decode-stage controller for the five-stage MIPS pipeline. It extends the plain combinational decode with mult/div/mfhi/mflo, a fixed RegWrite for jr/nop, and a Tuse/Tnew stall unit. The stall unit tracks E and M destinations in internal shadow registers, and a busy counter interlocks the multi-cycle multiply/divide unit. It sits between the F/D pipeline register and the D/E register, and drives the stall/flush inputs of both.

---
 rtl/ctrl_pkg.sv | 37 +++
 rtl/d_ctrl_hazard_if.sv | 23 ++
 rtl/d_ctrl_hazard_md_busy_tracker.sv | 19 +
 rtl/d_ctrl_hazard.sv | 82 ++++++++
 tb/tb_d_ctrl_hazard.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings, Tuse/Tnew types and hazard helpers for the decode controller
package ctrl_pkg;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;
  typedef enum logic [1:0] {EXT_SIGN = 2'b00, EXT_ZERO = 2'b01, EXT_LUI = 2'b10} ext_sel_e;
  typedef enum logic [1:0] {DST_RT = 2'b00, DST_RD = 2'b01, DST_RA = 2'b10} reg_dst_e;
  typedef enum logic [1:0] {WS_ALU = 2'b00, WS_EXT = 2'b01, WS_PC8 = 2'b10, WS_HILO = 2'b11} write_sel_e;
  typedef enum logic [1:0] {MD_NONE = 2'b00, MD_MULT = 2'b01, MD_DIV = 2'b10, MD_HILO = 2'b11} md_op_e;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam int T_W = 2;
  typedef logic [T_W-1:0] t_t;
  localparam t_t T0 = 2'd0;
  localparam t_t T1 = 2'd1;
  localparam t_t T2 = 2'd2;
  function automatic t_t dec_tnew(input t_t t);
    return t == '0 ? '0 : t - 1'b1;
  endfunction
  // A source hazards when its producer in E or M still needs more cycles than the consumer can wait
  function automatic logic raw_haz(input logic [4:0] src, input t_t tuse, input logic [4:0] e_dst,
                                   input t_t e_tnew, input logic [4:0] m_dst, input t_t m_tnew);
    return src != '0 && ((src == e_dst && e_tnew > tuse) || (src == m_dst && m_tnew > tuse));
  endfunction
endpackage

// File: rtl/d_ctrl_hazard_if.sv
// d_ctrl_hazard_if: instruction in D plus every decode and hazard control output
interface d_ctrl_hazard_if;
  logic [31:0] instr_d;
  logic        reg_write;
  logic [1:0]  ext_sel;
  logic [1:0]  reg_dst;
  logic [1:0]  write_sel;
  logic        alu_src;
  logic [3:0]  alu_ctrl;
  logic        branch;
  logic        mem_write;
  logic        mem_to_reg;
  logic        jump;
  logic        jr;
  logic [1:0]  md_op;
  logic        stall;
  logic        flush_e;
  logic        md_busy;
  modport master (output instr_d, input reg_write, ext_sel, reg_dst, write_sel, alu_src, alu_ctrl,
                  branch, mem_write, mem_to_reg, jump, jr, md_op, stall, flush_e, md_busy);
  modport slave (input instr_d, output reg_write, ext_sel, reg_dst, write_sel, alu_src, alu_ctrl,
                 branch, mem_write, mem_to_reg, jump, jr, md_op, stall, flush_e, md_busy);
endinterface

// File: rtl/d_ctrl_hazard_md_busy_tracker.sv
// md_busy_tracker: busy window counter for the multi-cycle multiply/divide unit
module md_busy_tracker #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic issue_mul,
  input  logic issue_div,
  output logic md_busy
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    md_busy = cnt_q != '0;
    cnt_d = issue_mul ? CNT_W'(MUL_CYCLES) : issue_div ? CNT_W'(DIV_CYCLES) : cnt_q - CNT_W'(md_busy);
  end
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/d_ctrl_hazard.sv
// d_ctrl_hazard: MIPS decode-stage controller with Tuse/Tnew stall unit and mul/div interlock
module d_ctrl_hazard import ctrl_pkg::*; #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic reset,
  d_ctrl_hazard_if.slave bus
);
  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, d_dst;
  logic r, is_add, is_sub, is_jr, is_mult, is_div, is_mfhi, is_mflo;
  logic is_ori, is_lw, is_sw, is_beq, is_lui, is_jal;
  logic use_rs, use_rt, issue_mul, issue_div, unused_shamt;
  t_t tuse_rs, tuse_rt, d_tnew;
  logic [4:0] e_dst_q, e_dst_d, m_dst_q, m_dst_d;
  t_t e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d;
  always_comb begin
    op = bus.instr_d[31:26];
    rs = bus.instr_d[25:21];
    rt = bus.instr_d[20:16];
    rd = bus.instr_d[15:11];
    fn = bus.instr_d[5:0];
    unused_shamt = ^bus.instr_d[10:6];
    r = op == OP_R;
    is_add = r && fn == FN_ADD;
    is_sub = r && fn == FN_SUB;
    is_jr = r && fn == FN_JR;
    is_mult = r && fn == FN_MULT;
    is_div = r && fn == FN_DIV;
    is_mfhi = r && fn == FN_MFHI;
    is_mflo = r && fn == FN_MFLO;
    is_ori = op == OP_ORI;
    is_lw = op == OP_LW;
    is_sw = op == OP_SW;
    is_beq = op == OP_BEQ;
    is_lui = op == OP_LUI;
    is_jal = op == OP_JAL;
    bus.reg_write = is_add | is_sub | is_mfhi | is_mflo | is_ori | is_lw | is_lui | is_jal;
    bus.ext_sel = is_ori ? EXT_ZERO : is_lui ? EXT_LUI : EXT_SIGN;
    bus.reg_dst = (is_add | is_sub | is_mfhi | is_mflo) ? DST_RD : is_jal ? DST_RA : DST_RT;
    bus.write_sel = is_lui ? WS_EXT : is_jal ? WS_PC8 : (is_mfhi | is_mflo) ? WS_HILO : WS_ALU;
    bus.alu_src = is_ori | is_lw | is_sw;
    bus.alu_ctrl = (is_add | is_lw | is_sw) ? ALU_ADD : (is_sub | is_beq) ? ALU_SUB : is_ori ? ALU_OR : 4'b0000;
    bus.branch = is_beq;
    bus.mem_write = is_sw;
    bus.mem_to_reg = is_lw;
    bus.jump = is_jal | is_jr;
    bus.jr = is_jr;
    bus.md_op = is_mult ? MD_MULT : is_div ? MD_DIV : (is_mfhi | is_mflo) ? MD_HILO : MD_NONE;
    d_dst = !bus.reg_write ? 5'd0 : bus.reg_dst == DST_RD ? rd : bus.reg_dst == DST_RA ? 5'd31 : rt;
    d_tnew = is_lw ? T2 : (is_add | is_sub | is_ori | is_mfhi | is_mflo) ? T1 : T0;
    use_rs = is_beq | is_jr | is_add | is_sub | is_ori | is_lw | is_sw | is_mult | is_div;
    tuse_rs = (is_beq | is_jr) ? T0 : T1;
    use_rt = is_beq | is_add | is_sub | is_mult | is_div | is_sw;
    tuse_rt = is_beq ? T0 : is_sw ? T2 : T1;
    bus.stall = (use_rs && raw_haz(rs, tuse_rs, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q))
             || (use_rt && raw_haz(rt, tuse_rt, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q))
             || (bus.md_op != MD_NONE && bus.md_busy);
    bus.flush_e = bus.stall;
    issue_mul = is_mult && !bus.stall;
    issue_div = is_div && !bus.stall;
    e_dst_d = bus.stall ? 5'd0 : d_dst;
    e_tnew_d = bus.stall ? T0 : d_tnew;
    m_dst_d = e_dst_q;
    m_tnew_d = dec_tnew(e_tnew_q);
  end
  always_ff @(posedge clk) begin
    e_dst_q <= reset ? 5'd0 : e_dst_d;
    e_tnew_q <= reset ? T0 : e_tnew_d;
    m_dst_q <= reset ? 5'd0 : m_dst_d;
    m_tnew_q <= reset ? T0 : m_tnew_d;
  end
  md_busy_tracker #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) u_md_busy (
    .clk(clk),
    .reset(reset),
    .issue_mul(issue_mul),
    .issue_div(issue_div),
    .md_busy(bus.md_busy)
  );
endmodule

// File: tb/tb_d_ctrl_hazard.sv
// tb_d_ctrl_hazard: directed checks of decode, data stalls and the mul/div busy window
module tb_d_ctrl_hazard;
  logic clk = 0;
  logic reset = 1;
  int passed = 0;
  int total = 0;
  int s;
  d_ctrl_hazard_if bus();
  d_ctrl_hazard #(.MUL_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end
  function automatic logic [31:0] rtype(input int rs_, input int rt_, input int rd_, input logic [5:0] fn);
    return {6'b000000, 5'(rs_), 5'(rt_), 5'(rd_), 5'b00000, fn};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input int rs_, input int rt_, input logic [15:0] imm);
    return {op, 5'(rs_), 5'(rt_), imm};
  endfunction
  function automatic logic [18:0] ctl();
    return {bus.reg_write, bus.ext_sel, bus.reg_dst, bus.write_sel, bus.alu_src, bus.alu_ctrl,
            bus.branch, bus.mem_write, bus.mem_to_reg, bus.jump, bus.jr, bus.md_op};
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic nops(input int n);
    bus.instr_d = 32'h0;
    repeat (n) tick();
  endtask
  // Hold ins in D while stalled; return stall cycles once it issues (99 if it never does)
  task automatic run_d(input logic [31:0] ins, output int stalls);
    bus.instr_d = ins;
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.stall) begin
        tick();
        return;
      end
      stalls++;
      tick();
    end
    stalls = 99;
  endtask
  task automatic peek(input logic [31:0] ins);
    bus.instr_d = ins;
    @(negedge clk);
  endtask
  initial begin
    bus.instr_d = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("reset_all_zero", {13'b0, ctl(), bus.stall, bus.flush_e, bus.md_busy}, 32'h0);
    check("reset_md_busy", 32'(bus.md_busy), 0);
    peek(itype(6'b100011, 2, 1, 16'd4)); tick();
    check("dec_lw", 32'({bus.reg_write, bus.reg_dst, bus.alu_src, bus.alu_ctrl, bus.mem_to_reg, bus.mem_write}), 32'b1_00_1_0010_1_0);
    peek(itype(6'b001101, 3, 7, 16'd5));
    check("dec_ori", 32'({bus.reg_write, bus.ext_sel, bus.alu_src, bus.alu_ctrl}), 32'b1_01_1_0001);
    tick();
    peek(itype(6'b001111, 0, 8, 16'h1234));
    check("dec_lui", 32'({bus.reg_write, bus.ext_sel, bus.write_sel, bus.reg_dst}), 32'b1_10_01_00);
    tick();
    peek(itype(6'b000011, 0, 0, 16'h0010));
    check("dec_jal", 32'({bus.reg_write, bus.reg_dst, bus.write_sel, bus.jump, bus.jr}), 32'b1_10_10_1_0);
    tick();
    peek(itype(6'b101011, 9, 10, 16'd8));
    check("dec_sw", 32'({bus.reg_write, bus.mem_write, bus.alu_src, bus.alu_ctrl}), 32'b0_1_1_0010);
    tick();
    peek(itype(6'b000100, 11, 12, 16'd3));
    check("dec_beq", 32'({bus.reg_write, bus.branch, bus.alu_ctrl}), 32'b0_1_0110);
    tick();
    peek(rtype(13, 14, 15, 6'b100010));
    check("dec_sub", 32'({bus.reg_write, bus.reg_dst, bus.alu_ctrl}), 32'b1_01_0110);
    tick();
    peek(rtype(0, 0, 16, 6'b010000));
    check("dec_mfhi", 32'({bus.reg_write, bus.write_sel, bus.md_op}), 32'b1_11_11);
    tick();
    peek(itype(6'b001000, 17, 18, 16'd1));
    check("dec_unsupported", 32'({ctl(), bus.stall}), 32'h0);
    tick();
    nops(2);
    run_d(itype(6'b100011, 0, 1, 16'd0), s);
    run_d(rtype(1, 1, 2, 6'b100000), s);
    check("lw_add_stall", 32'(s), 1);
    nops(2);
    run_d(itype(6'b100011, 0, 1, 16'd0), s);
    run_d(itype(6'b000100, 1, 0, 16'd0), s);
    check("lw_beq_stall", 32'(s), 2);
    nops(2);
    run_d(rtype(0, 0, 3, 6'b100000), s);
    run_d(itype(6'b000100, 3, 0, 16'd0), s);
    check("add_beq_stall", 32'(s), 1);
    nops(2);
    run_d(itype(6'b001101, 0, 0, 16'd5), s);
    run_d(itype(6'b000100, 0, 0, 16'd0), s);
    check("zero_reg_no_stall", 32'(s), 0);
    nops(2);
    run_d(rtype(0, 0, 4, 6'b100000), s);
    run_d(itype(6'b101011, 0, 4, 16'd0), s);
    check("add_sw_rt_no_stall", 32'(s), 0);
    nops(2);
    run_d(itype(6'b100011, 0, 5, 16'd0), s);
    run_d(itype(6'b101011, 5, 6, 16'd0), s);
    check("lw_sw_rs_stall", 32'(s), 1);
    nops(2);
    peek(rtype(1, 2, 0, 6'b011000));
    check("mult_decode", 32'({bus.reg_write, bus.md_op, bus.stall}), 32'b0_01_0);
    tick();
    peek(rtype(0, 0, 3, 6'b010010));
    check("mult_busy_first", 32'({bus.md_busy, bus.stall, bus.flush_e}), 32'b111);
    tick();
    run_d(rtype(0, 0, 3, 6'b010010), s);
    check("mflo_remaining_stall", 32'(s), 4);
    check("mult_busy_cleared", 32'(bus.md_busy), 0);
    run_d(rtype(1, 2, 0, 6'b011010), s);
    check("div_issue", 32'(s), 0);
    run_d(rtype(0, 0, 7, 6'b010000), s);
    check("div_mfhi_stall", 32'(s), 10);
    run_d(rtype(4, 5, 0, 6'b011010), s);
    nops(2);
    reset = 1;
    @(negedge clk);
    check("busy_before_reset", 32'(bus.md_busy), 1);
    tick();
    reset = 0;
    @(negedge clk);
    check("busy_after_reset", 32'(bus.md_busy), 0);
    run_d(rtype(0, 0, 3, 6'b010000), s);
    check("mfhi_after_reset", 32'(s), 0);
    peek(rtype(31, 0, 0, 6'b001000));
    check("jr_ctrl", 32'({bus.reg_write, bus.jump, bus.jr, bus.stall}), 32'b0_1_1_0);
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
